comp_layer: RTL and testbench

- Post-dense decode stage, occupying the COMP step of the pipeline state sequence.
- Consumes the dense_layer score vector: N positions × CHAR_NUM signed logits.
- For each position, produces the index of the largest logit as a CHAR_LEN-bit character code, packed into N×CHAR_LEN for axi_stream_output.
- Sequential argmax: all N positions are scanned in parallel, one candidate character per cycle.

---
 rtl/comp_layer_pkg.sv | 24 ++
 rtl/comp_layer_argmax_lane.sv | 39 +++
 rtl/comp_layer.sv | 106 ++++++++++
 tb/tb_comp_layer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/comp_layer_pkg.sv
// Shared types and defaults for the COMP (argmax decode) stage.
package comp_layer_pkg;

   localparam int N_DEF        = 10;
   localparam int CHAR_NUM_DEF = 200;
   localparam int CHAR_LEN_DEF = 8;
   localparam int N_LEN_DEF    = 16;

   // Top-level pipeline state register width and the code of the COMP step.
   localparam int              STATE_LEN = 3;
   localparam [STATE_LEN-1:0] ST_COMP   = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2,
      ST_WAIT = 2'd3
   } comp_state_t;

   function automatic int cnt_width(input int char_num);
      return $clog2(char_num + 1);
   endfunction

endpackage

// File: rtl/comp_layer_argmax_lane.sv
// One character position: running signed maximum and the index where it was first seen.
module comp_layer_argmax_lane
   import comp_layer_pkg::*;
#(
   parameter int CHAR_LEN = CHAR_LEN_DEF,
   parameter int N_LEN    = N_LEN_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_init,
   input  logic                i_step,
   input  logic [N_LEN-1:0]    i_init_val,
   input  logic [N_LEN-1:0]    i_cand_val,
   input  logic [CHAR_LEN-1:0] i_cand_idx,
   output logic [CHAR_LEN-1:0] o_best_idx
);

   logic [N_LEN-1:0]    r_best_val;
   logic [CHAR_LEN-1:0] r_best_idx;
   logic                w_better;

   // Strict compare: on a tie the earlier (lower) index is kept.
   assign w_better   = $signed(i_cand_val) > $signed(r_best_val);
   assign o_best_idx = r_best_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_best_val <= '0;
         r_best_idx <= '0;
      end else if (i_init) begin
         r_best_val <= i_init_val;
         r_best_idx <= '0;
      end else if (i_step && w_better) begin
         r_best_val <= i_cand_val;
         r_best_idx <= i_cand_idx;
      end
   end

endmodule

// File: rtl/comp_layer.sv
// Sequential argmax over CHAR_NUM logits for all N positions in parallel, one candidate per cycle.
module comp_layer
   import comp_layer_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int CHAR_NUM = CHAR_NUM_DEF,
   parameter int CHAR_LEN = CHAR_LEN_DEF,
   parameter int N_LEN    = N_LEN_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         run,
   input  logic [N*CHAR_NUM*N_LEN-1:0]  d,
   output logic                         valid,
   output logic                         busy,
   output logic [N*CHAR_LEN-1:0]        q
);

   localparam int               CNT_W   = cnt_width(CHAR_NUM);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAR_NUM);

   comp_state_t                     r_state;
   logic [CNT_W-1:0]                r_cnt;
   logic [N*CHAR_NUM*N_LEN-1:0]     r_buf;
   logic                            r_valid;
   logic                            r_busy;
   logic [N*CHAR_LEN-1:0]           r_q;

   logic                            w_start;
   logic                            w_step;
   logic [CNT_W-1:0]                w_sel;
   logic [CHAR_LEN-1:0]             w_cand_idx;
   logic [N-1:0][CHAR_LEN-1:0]      w_best_idx;

   assign valid = r_valid;
   assign busy  = r_busy;
   assign q     = r_q;

   // Char 0 seeds the lanes straight from d on the start edge, so the buffer is
   // only read from char 1 onward; the select is parked at 0 on the final edge.
   assign w_start    = (r_state == ST_IDLE) && run;
   assign w_step     = (r_state == ST_SCAN) && run && (r_cnt != CNT_MAX);
   assign w_sel      = (r_cnt != CNT_MAX) ? r_cnt : '0;
   assign w_cand_idx = CHAR_LEN'(w_sel);

   for (genvar i = 0; i < N; i++) begin : g_lane
      comp_layer_argmax_lane #(
         .CHAR_LEN (CHAR_LEN),
         .N_LEN    (N_LEN)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .i_init     (w_start),
         .i_step     (w_step),
         .i_init_val (d[(i*CHAR_NUM)*N_LEN +: N_LEN]),
         .i_cand_val (r_buf[(i*CHAR_NUM + int'(w_sel))*N_LEN +: N_LEN]),
         .i_cand_idx (w_cand_idx),
         .o_best_idx (w_best_idx[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_buf   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_q     <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (run) begin
                  r_buf   <= d;
                  r_cnt   <= CNT_W'(1);
                  r_busy  <= 1'b1;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!run) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (r_cnt == CNT_MAX) begin
                  r_q     <= w_best_idx;
                  r_valid <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= run ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
               // Hold off re-triggering until the top level drops run.
               if (!run) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comp_layer.sv
// Directed bench: small (N=2,CHAR_NUM=4), default-size and single-char instances.
module tb_comp_layer;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                run_s = 1'b0, run_b = 1'b0, run_t = 1'b0;
   logic [2*4*16-1:0]   d_s = '0;
   logic [10*200*16-1:0] d_b = '0;
   logic [15:0]         d_t = '0;
   logic                valid_s, busy_s, valid_b, busy_b, valid_t, busy_t;
   logic [15:0]         q_s;
   logic [79:0]         q_b;
   logic [7:0]          q_t;
   logic [79:0]         exp_b;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   comp_layer #(.N(2), .CHAR_NUM(4), .CHAR_LEN(8), .N_LEN(16)) u_small (
      .clk(clk), .rst(rst), .run(run_s), .d(d_s), .valid(valid_s), .busy(busy_s), .q(q_s));

   comp_layer u_big (
      .clk(clk), .rst(rst), .run(run_b), .d(d_b), .valid(valid_b), .busy(busy_b), .q(q_b));

   comp_layer #(.N(1), .CHAR_NUM(1), .CHAR_LEN(8), .N_LEN(16)) u_one (
      .clk(clk), .rst(rst), .run(run_t), .d(d_t), .valid(valid_t), .busy(busy_t), .q(q_t));

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // p0/p1 hold chars {c3,c2,c1,c0} of positions 0/1.
   task automatic set_s(input logic [63:0] p0, input logic [63:0] p1);
      d_s = {p1, p0};
   endtask

   initial begin
      // Reset state
      tick(); tick();
      chk("rst_valid_s", valid_s, 0);
      chk("rst_busy_s", busy_s, 0);
      chk("rst_q_s", q_s, 0);
      chk("rst_q_b", q_b, 0);
      chk("rst_busy_b", busy_b, 0);
      rst = 1'b0;
      tick();

      // Ramp: pos0 {1,2,3,4} -> 3, pos1 {4,3,2,1} -> 0; valid 4 cycles after start edge
      set_s({16'd4, 16'd3, 16'd2, 16'd1}, {16'd1, 16'd2, 16'd3, 16'd4});
      run_s = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("ramp_valid", valid_s, (k == 5));
         chk("ramp_busy", busy_s, 1);
      end
      chk("ramp_q", q_s, 16'h0003);

      // Held run: no retrigger, busy drops after DONE
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("held_valid", valid_s, 0);
         chk("held_busy", busy_s, 0);
      end
      chk("held_q", q_s, 16'h0003);
      run_s = 1'b0;
      tick();

      // Signed and ties: pos0 {-5,-1,-1,-3} -> 1, pos1 all 0x8000 -> 0
      set_s({16'hFFFD, 16'hFFFF, 16'hFFFF, 16'hFFFB}, {4{16'h8000}});
      run_s = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("sgn_valid", valid_s, (k == 5));
      end
      chk("sgn_q", q_s, 16'h0001);
      run_s = 1'b0;
      tick();
      chk("sgn_idle_busy", busy_s, 0);

      // Input isolation: d scrambled after the start edge
      set_s({16'd9, 16'd0, 16'd0, 16'd0}, {16'd0, 16'd0, 16'd7, 16'd0});
      run_s = 1'b1;
      tick();
      for (int k = 2; k <= 5; k++) begin
         if (k % 2 == 0) set_s({16'd0, 16'd0, 16'd0, 16'd100}, {16'd100, 16'd0, 16'd0, 16'd0});
         else            set_s({16'd0, 16'd200, 16'd0, 16'd0}, {16'd0, 16'd0, 16'd0, 16'd300});
         tick();
         chk("iso_valid", valid_s, (k == 5));
      end
      chk("iso_q", q_s, 16'h0103);
      run_s = 1'b0;
      tick();

      // Abort by run drop at scan cycle 2: q unchanged, FSM back in IDLE
      set_s({16'd0, 16'd0, 16'd5, 16'd0}, {16'd0, 16'd5, 16'd0, 16'd0});
      run_s = 1'b1;
      tick(); tick();
      run_s = 1'b0;
      tick();
      chk("rabort_busy", busy_s, 0);
      chk("rabort_valid", valid_s, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rabort_novalid", valid_s, 0);
      end
      chk("rabort_q", q_s, 16'h0103);
      run_s = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk("restart_valid", valid_s, (k == 5));
      end
      chk("restart_q", q_s, 16'h0201);
      run_s = 1'b0;
      tick();

      // Abort by reset at scan cycle 2
      set_s({16'd7, 16'd0, 16'd0, 16'd0}, {16'd7, 16'd0, 16'd0, 16'd0});
      run_s = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      run_s = 1'b0;
      tick();
      chk("xabort_valid", valid_s, 0);
      chk("xabort_busy", busy_s, 0);
      chk("xabort_q", q_s, 0);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("xabort_novalid", valid_s, 0);
      end

      // CHAR_NUM=1: latency 1, index 0
      d_t = 16'h1234;
      run_t = 1'b1;
      tick();
      chk("one_valid0", valid_t, 0);
      chk("one_busy0", busy_t, 1);
      tick();
      chk("one_valid1", valid_t, 1);
      chk("one_q", q_t, 0);
      run_t = 1'b0;
      tick();
      chk("one_busy_end", busy_t, 0);

      // Default size: one-hot max at char 57, position 9 at char 199
      for (int i = 0; i < 9; i++) d_b[(i*200+57)*16 +: 16] = 16'h7FFF;
      d_b[(9*200+199)*16 +: 16] = 16'h7FFF;
      for (int i = 0; i < 10; i++) exp_b[i*8 +: 8] = (i == 9) ? 8'd199 : 8'd57;
      run_b = 1'b1;
      for (int k = 1; k <= 201; k++) begin
         tick();
         chk("big_valid", valid_b, (k == 201));
         chk("big_busy", busy_b, 1);
      end
      chk("big_q", q_b, exp_b);
      run_b = 1'b0;
      tick();
      chk("big_busy_end", busy_b, 0);
      chk("big_valid_end", valid_b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
